regwb_queue: RTL and testbench
==============================

Name: regwb_queue

Overview:
- Write-back queue that feeds the single write port (wn/we/d) of the 32x32 two-read-port register file.
- Accepts results from two producers over valid/ready: A is the ALU/load path, B is the multi-cycle mul/div unit.
- Buffers results in a small FIFO and drains one entry per cycle into the register file whenever the port is free.
- Provides bypass lookup so reads on rna/rnb see pending writes that the register file has not yet committed.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 5, register-number width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- a_valid  in  1  producer A has a result.
- a_rn  in  AW  producer A destination register.
- a_d  in  DW  producer A data.
- a_ready  out  1  producer A result accepted this cycle.
- b_valid  in  1  producer B has a result.
- b_rn  in  AW  producer B destination register.
- b_d  in  DW  producer B data.
- b_ready  out  1  producer B result accepted this cycle.
- port_busy  in  1  register-file write port is unavailable this cycle; inhibits drain.
- wn  out  AW  register-file write number.
- we  out  1  register-file write enable.
- d  out  DW  register-file write data.
- rna  in  AW  read address A, same as the register-file rna.
- rnb  in  AW  read address B, same as the register-file rnb.
- hita  out  1  a pending write to rna exists.
- fwda  out  DW  newest pending data for rna.
- hitb  out  1  a pending write to rnb exists.
- fwdb  out  DW  newest pending data for rnb.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, clr=1): head, tail and count go to 0; every entry's valid bit is cleared; empty=1, full=0, we=0, hita=hitb=0. Entry data is don't-care.
- Reset mid-operation discards all pending writes; nothing is written after clr asserts.
- Ready rules:
  - a_ready = !full.
  - b_ready = !full && !a_valid. A has fixed priority; B holds its valid and data until it sees ready.
- Accept (push): at most one push per cycle.
  - The push comes from A if a_valid && a_ready, else from B if b_valid && b_ready.
  - Push stores {rn, d} at tail; tail increments modulo DEPTH.
  - A push with rn == 0 is accepted (ready handshake completes) but not stored; count is unchanged. r0 stays hardwired zero.
- Drain (pop):
  - Combinational outputs: we = !empty && !port_busy; wn = head.rn; d = head.d.
  - When we=1, head increments modulo DEPTH at the edge, so the register file and the queue commit on the same edge.
  - wn and d are don't-care when we=0.
- Simultaneous push and pop: count is unchanged and pointers advance independently.
- Full-cycle rules:
  - A full cycle blocks the push even if a pop also occurs; ready does not depend on port_busy.
  - Full plus pop frees a slot for the next cycle.
- Latency:
  - A result accepted at edge N appears on wn/we/d in cycle N+1 at the earliest, if the queue was empty and port_busy=0.
  - The register-file contents update at edge N+1.
- Bypass (combinational):
  - Scan all valid entries from newest (tail-1) to oldest (head), including the head being written this cycle.
  - hita=1 if any entry rn == rna and rna != 0; fwda = data of the newest matching entry.
  - rnb/hitb/fwdb work identically.
  - Results being pushed in the current cycle are not visible until the next cycle.
  - fwda/fwdb are 0 when there is no hit.
  - The consumer mux is qa_eff = hita ? fwda : qa.
- Write ordering: entries drain strictly FIFO, so a later write to the same register always wins in the register file.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally; full and empty are derived from count, not from pointer equality.

Decomposition:
- Shared package regwb_pkg:
  - constants REG_AW=5 and REG_DW=32;
  - typedef wb_entry_t {logic [AW-1:0] rn; logic [DW-1:0] d;}.
- One natural sub-module, regwb_match: priority search from newest to oldest over entry valid/rn/data for a single read address, returning hit and data.
  - Instantiate it twice, for the a and b read ports.
- FIFO storage and pointers stay in the top module.

Test Plan:
1. Reset and single result:
   - Stimulus: assert clr mid-stream with 3 entries pending, then release; push A {rn=3, d=0x11}.
   - Response: count drops to 0 asynchronously and we=0; after release, the next cycle shows we=1, wn=3, d=0x11, then empty=1.
2. Full, stall and drain:
   - Stimulus: port_busy=1; push 5 A results to r1..r5.
   - Response: the first 4 are accepted; full=1; a_ready=0 on the 5th.
   - Stimulus: drop port_busy.
   - Response: writes drain in order r1, r2, r3, r4, one per cycle; the 5th is accepted in the first cycle after the first pop.
3. Priority:
   - Stimulus: a_valid and b_valid both high for 2 cycles.
   - Response: b_ready=0 both cycles, and B is accepted in the first cycle with a_valid=0.
   - Response: B's data is held stable and is written exactly once.
4. Bypass newest wins:
   - Stimulus: port_busy=1; enqueue r7=0xAA, then r7=0xBB; set rna=7, rnb=8.
   - Response: hita=1 and fwda=0xBB; hitb=0 and fwdb=0.
   - Response: after draining the first entry, fwda is still 0xBB; after draining both, hita=0.
5. r0 handling:
   - Stimulus: push A {rn=0, d=0xFFFF}.
   - Response: a_ready=1, count stays 0, we never asserts, and rna=0 gives hita=0.
6. Wrap-around stress:
   - Stimulus: random push/pop with port_busy toggled for 1000 cycles.
   - Response: the write sequence matches the scoreboard's accepted nonzero-rn order; count never exceeds DEPTH; bypass equals the reference model every cycle.

Source files
------------

// File: rtl/regwb_pkg.sv
// Shared types and widths for the register-file write-back queue.
package regwb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rn;
    logic [REG_DW-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/regwb_match.sv
// Bypass search for one read address over age-ordered queue entries.
// Entry 0 is the oldest (head); later entries override, so the newest match wins.
module regwb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0] vld,
  input  logic [AW-1:0]    rn  [DEPTH],
  input  logic [DW-1:0]    dat [DEPTH],
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (rn[i] == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = dat[i];
      end
    end
  end

endmodule

// File: rtl/regwb_queue.sv
// Write-back queue in front of the register-file write port: two prioritised
// producers, FIFO drain when the port is free, and read bypass of pending writes.
module regwb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       a_valid,
  input  logic [AW-1:0]              a_rn,
  input  logic [DW-1:0]              a_d,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [AW-1:0]              b_rn,
  input  logic [DW-1:0]              b_d,
  output logic                       b_ready,
  input  logic                       port_busy,
  output logic [AW-1:0]              wn,
  output logic                       we,
  output logic [DW-1:0]              d,
  input  logic [AW-1:0]              rna,
  input  logic [AW-1:0]              rnb,
  output logic                       hita,
  output logic [DW-1:0]              fwda,
  output logic                       hitb,
  output logic [DW-1:0]              fwdb,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    rn_q  [DEPTH];
  logic [AW-1:0]    rn_d  [DEPTH];
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DW-1:0]    dat_d [DEPTH];

  logic          take_a, take_b, push, pop;
  logic [AW-1:0] push_rn;
  logic [DW-1:0] push_dat;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign a_ready = !full;
  assign b_ready = !full && !a_valid;
  assign take_a  = a_valid && a_ready;
  assign take_b  = !take_a && b_valid && b_ready;
  assign push_rn  = take_a ? a_rn : b_rn;
  assign push_dat = take_a ? a_d  : b_d;
  // r0 writes complete the handshake but are dropped here.
  assign push = (take_a || take_b) && (push_rn != '0);

  assign we  = !empty && !port_busy;
  assign pop = we;
  assign wn  = rn_q[head_q];
  assign d   = dat_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    rn_d    = rn_q;
    dat_d   = dat_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = PW'(head_q + PW'(1));
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      rn_d[tail_q]    = push_rn;
      dat_d[tail_q]   = push_dat;
      tail_d          = PW'(tail_q + PW'(1));
    end
    count_d = CW'(count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset; valid_q guards every use.
  always_ff @(posedge clk) begin
    rn_q  <= rn_d;
    dat_q <= dat_d;
  end

  logic [DEPTH-1:0] ord_vld;
  logic [AW-1:0]    ord_rn  [DEPTH];
  logic [DW-1:0]    ord_dat [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_vld[i] = valid_q[PW'(head_q + PW'(i))];
      ord_rn[i]  = rn_q[PW'(head_q + PW'(i))];
      ord_dat[i] = dat_q[PW'(head_q + PW'(i))];
    end
  end

  regwb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
    .vld  (ord_vld),
    .rn   (ord_rn),
    .dat  (ord_dat),
    .addr (rna),
    .hit  (hita),
    .data (fwda)
  );

  regwb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
    .vld  (ord_vld),
    .rn   (ord_rn),
    .dat  (ord_dat),
    .addr (rnb),
    .hit  (hitb),
    .data (fwdb)
  );

endmodule

// File: tb/tb_regwb_queue.sv
// Directed and randomised checks of regwb_queue against hand values and a queue model.
module tb_regwb_queue;

  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic          a_valid, b_valid, a_ready, b_ready, port_busy, we;
  logic [AW-1:0] a_rn, b_rn, wn, rna, rnb;
  logic [DW-1:0] a_d, b_d, d, fwda, fwdb;
  logic          hita, hitb, full, empty;
  logic [2:0]    count;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [AW-1:0] rn;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  regwb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_rn(a_rn), .a_d(a_d), .a_ready(a_ready),
    .b_valid(b_valid), .b_rn(b_rn), .b_d(b_d), .b_ready(b_ready),
    .port_busy(port_busy), .wn(wn), .we(we), .d(d),
    .rna(rna), .rnb(rnb), .hita(hita), .fwda(fwda), .hitb(hitb), .fwdb(fwdb),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          exp_we, exp_full, acc_a, acc_b, h_a, h_b;
    logic [DW-1:0] f_a, f_b;

    clr = 1'b1; a_valid = 0; b_valid = 0; a_rn = 0; b_rn = 0; a_d = 0; b_d = 0;
    port_busy = 0; rna = 0; rnb = 0;
    #12;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_hita", hita, 1'b0);
    step();
    clr = 1'b0;
    step();

    // 1: reset mid-stream, then a single result
    port_busy = 1;
    for (int i = 1; i <= 3; i++) begin
      a_valid = 1; a_rn = AW'(i); a_d = 32'h50 + i;
      step();
    end
    a_valid = 0; rna = 1;
    #1;
    chk("t1_pending", count, 3'd3);
    chk("t1_pend_hit", hita, 1'b1);
    port_busy = 0;
    #1;
    clr = 1;
    #1;
    chk("t1_clr_count", count, 3'd0);
    chk("t1_clr_we", we, 1'b0);
    chk("t1_clr_hita", hita, 1'b0);
    step();
    clr = 0;
    step();
    chk("t1_post_clr_we", we, 1'b0);
    a_valid = 1; a_rn = 3; a_d = 32'h11;
    #1;
    chk("t1_a_ready", a_ready, 1'b1);
    step();
    a_valid = 0;
    #1;
    chk("t1_we", we, 1'b1);
    chk("t1_wn", wn, 5'd3);
    chk("t1_d", d, 32'h11);
    step();
    chk("t1_empty", empty, 1'b1);
    chk("t1_we_off", we, 1'b0);

    // 2: full, stall, drain
    port_busy = 1;
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1; a_rn = AW'(i); a_d = 32'h100 + i;
      #1;
      chk("t2_acc_ready", a_ready, 1'b1);
      step();
    end
    a_rn = 5; a_d = 32'h105;
    #1;
    chk("t2_full", full, 1'b1);
    chk("t2_count", count, 3'd4);
    chk("t2_5th_ready", a_ready, 1'b0);
    chk("t2_busy_we", we, 1'b0);
    step();
    chk("t2_hold_count", count, 3'd4);
    port_busy = 0;
    #1;
    chk("t2_full_pop_ready", a_ready, 1'b0);
    chk("t2_we1", we, 1'b1);
    chk("t2_wn1", wn, 5'd1);
    chk("t2_d1", d, 32'h101);
    step();
    chk("t2_after_pop_ready", a_ready, 1'b1);
    chk("t2_count3", count, 3'd3);
    chk("t2_wn2", wn, 5'd2);
    step();
    a_valid = 0;
    #1;
    chk("t2_pushpop_count", count, 3'd3);
    chk("t2_wn3", wn, 5'd3);
    step();
    chk("t2_wn4", wn, 5'd4);
    step();
    chk("t2_wn5", wn, 5'd5);
    chk("t2_d5", d, 32'h105);
    step();
    chk("t2_empty", empty, 1'b1);

    // 3: A priority over B
    a_valid = 1; a_rn = 10; a_d = 32'hA1;
    b_valid = 1; b_rn = 11; b_d = 32'hB0B;
    #1;
    chk("t3_b_ready_c1", b_ready, 1'b0);
    step();
    chk("t3_wn10", wn, 5'd10);
    a_rn = 12; a_d = 32'hA2;
    #1;
    chk("t3_b_ready_c2", b_ready, 1'b0);
    step();
    chk("t3_wn12", wn, 5'd12);
    a_valid = 0;
    #1;
    chk("t3_b_ready_c3", b_ready, 1'b1);
    step();
    b_valid = 0;
    #1;
    chk("t3_wn11", wn, 5'd11);
    chk("t3_d_b", d, 32'hB0B);
    chk("t3_we_b", we, 1'b1);
    step();
    chk("t3_b_once", we, 1'b0);

    // 4: bypass, newest wins
    port_busy = 1;
    rna = 7; rnb = 8;
    a_valid = 1; a_rn = 7; a_d = 32'hAA;
    #1;
    chk("t4_inflight_invisible", hita, 1'b0);
    step();
    a_d = 32'hBB;
    #1;
    chk("t4_first_hit", fwda, 32'hAA);
    step();
    a_valid = 0;
    #1;
    chk("t4_hita", hita, 1'b1);
    chk("t4_fwda", fwda, 32'hBB);
    chk("t4_hitb", hitb, 1'b0);
    chk("t4_fwdb", fwdb, 32'h0);
    port_busy = 0;
    step();
    port_busy = 1;
    #1;
    chk("t4_after1_hita", hita, 1'b1);
    chk("t4_after1_fwda", fwda, 32'hBB);
    chk("t4_after1_count", count, 3'd1);
    port_busy = 0;
    step();
    chk("t4_after2_hita", hita, 1'b0);
    chk("t4_after2_fwda", fwda, 32'h0);
    chk("t4_after2_empty", empty, 1'b1);

    // 5: r0 writes are accepted and dropped
    a_valid = 1; a_rn = 0; a_d = 32'hFFFF; rna = 0;
    #1;
    chk("t5_ready", a_ready, 1'b1);
    step();
    a_valid = 0;
    #1;
    chk("t5_count", count, 3'd0);
    chk("t5_we", we, 1'b0);
    chk("t5_hita", hita, 1'b0);
    step();
    chk("t5_we_later", we, 1'b0);

    // 6: random push/pop against queue model
    b_valid = 0;
    q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      port_busy = ($urandom_range(0, 2) == 0);
      a_valid = $urandom_range(0, 1);
      a_rn = AW'($urandom_range(0, 7));
      a_d = $urandom;
      if (!b_valid) begin
        b_valid = ($urandom_range(0, 2) == 0);
        b_rn = AW'($urandom_range(0, 7));
        b_d = $urandom;
      end
      rna = AW'($urandom_range(0, 7));
      rnb = AW'($urandom_range(0, 7));
      #1;
      exp_full = (q.size() == DEPTH);
      exp_we = (q.size() != 0) && !port_busy;
      chk("r_count", count, 64'(q.size()));
      chk("r_a_ready", a_ready, !exp_full);
      chk("r_b_ready", b_ready, !exp_full && !a_valid);
      chk("r_we", we, exp_we);
      if (exp_we) begin
        chk("r_wn", wn, q[0].rn);
        chk("r_d", d, q[0].d);
      end
      h_a = 0; f_a = 0; h_b = 0; f_b = 0;
      foreach (q[i]) begin
        if (q[i].rn == rna && rna != 0) begin h_a = 1; f_a = q[i].d; end
        if (q[i].rn == rnb && rnb != 0) begin h_b = 1; f_b = q[i].d; end
      end
      chk("r_hita", hita, h_a);
      chk("r_fwda", fwda, f_a);
      chk("r_hitb", hitb, h_b);
      chk("r_fwdb", fwdb, f_b);
      acc_a = a_valid && !exp_full;
      acc_b = !acc_a && b_valid && !exp_full && !a_valid;
      step();
      if (exp_we) void'(q.pop_front());
      if (acc_a && a_rn != 0) q.push_back('{rn: a_rn, d: a_d});
      if (acc_b && b_rn != 0) q.push_back('{rn: b_rn, d: b_d});
      if (acc_b) b_valid = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
